cmp_seq_driver: RTL and testbench

Sequential initiator for the 8-bit ALU comparator interface. Accepts operand pairs over a valid/ready handshake and drives them onto the comparator inputs, holding them for a programmable settle time. It then samples the comparator's flag outputs and returns a classified result (less / equal / greater) over a second valid/ready handshake. It also keeps saturating per-class hit counters, so the comparator can be exercised from on-chip logic rather than only from a bench.

---
 rtl/cmp_seq_driver_if.sv | 59 +++++
 rtl/cmp_seq_driver.sv | 181 ++++++++++++++++++
 tb/tb_cmp_seq_driver.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_seq_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cmp_seq_driver_if
// ----------------------------------------------------------------------------
// Bundles the three buses around cmp_seq_driver:
//   req_* : operand-pair request handshake (valid/ready, A, B)
//   cmp_* : drive/sense lines of the 8-bit ALU comparator
//   rsp_* : classified-result handshake (valid/ready, lt/eq/gt/err, y)
// Modports:
//   master : the environment (requester, comparator, result consumer)
//   slave  : the cmp_seq_driver block itself
// Parameters:
//   WIDTH  : operand / comparator data width
// Revision: 1.0 - initial release
// ============================================================================
interface cmp_seq_driver_if #(
  parameter int unsigned WIDTH = 8
);
  // request side
  logic             req_valid_in;
  logic             req_ready_out;
  logic [WIDTH-1:0] req_a_in;
  logic [WIDTH-1:0] req_b_in;
  // comparator side
  logic [WIDTH-1:0] cmp_a_out;
  logic [WIDTH-1:0] cmp_b_out;
  logic             cmp_en_n_out;
  logic [WIDTH-1:0] cmp_y_in;
  logic             cmp_carry_in;
  logic             cmp_zero_in;
  // response side
  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic             rsp_lt_out;
  logic             rsp_eq_out;
  logic             rsp_gt_out;
  logic [WIDTH-1:0] rsp_y_out;
  logic             rsp_err_out;

  modport master (
    output req_valid_in, req_a_in, req_b_in,
    output cmp_y_in, cmp_carry_in, cmp_zero_in,
    output rsp_ready_in,
    input  req_ready_out,
    input  cmp_a_out, cmp_b_out, cmp_en_n_out,
    input  rsp_valid_out, rsp_lt_out, rsp_eq_out, rsp_gt_out, rsp_y_out, rsp_err_out
  );

  modport slave (
    input  req_valid_in, req_a_in, req_b_in,
    input  cmp_y_in, cmp_carry_in, cmp_zero_in,
    input  rsp_ready_in,
    output req_ready_out,
    output cmp_a_out, cmp_b_out, cmp_en_n_out,
    output rsp_valid_out, rsp_lt_out, rsp_eq_out, rsp_gt_out, rsp_y_out, rsp_err_out
  );
endinterface
`default_nettype wire

// File: rtl/cmp_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cmp_seq_driver
// ----------------------------------------------------------------------------
// Sequential initiator for the ALU comparator. Accepts an operand pair,
// drives it onto the comparator for SETTLE cycles, samples the carry/zero
// flags, and returns a one-hot less/equal/greater class (or an error when
// the flags are contradictory). Keeps saturating per-class hit counters.
//
// Ports:
//   clk_in      : clock, rising edge
//   rst_n_in    : asynchronous active-low reset
//   bus         : cmp_seq_driver_if.slave (req_*, cmp_*, rsp_* signals)
//   cnt_clr_in  : synchronous clear of all hit counters
//   cnt_lt_out  : saturating count of "less" results
//   cnt_eq_out  : saturating count of "equal" results
//   cnt_gt_out  : saturating count of "greater" results
// Parameters:
//   WIDTH  : operand width (must match the interface instance)
//   SETTLE : comparator settle cycles, 1..15
//   CNT_W  : hit counter width
// Revision: 1.0 - initial release
// ============================================================================
module cmp_seq_driver #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  cmp_seq_driver_if.slave  bus,
  input  logic             cnt_clr_in,
  output logic [CNT_W-1:0] cnt_lt_out,
  output logic [CNT_W-1:0] cnt_eq_out,
  output logic [CNT_W-1:0] cnt_gt_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter reaches 0 after SETTLE cycles in DRIVE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             en_n_q, en_n_d;
  logic             valid_q, valid_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    en_n_d   = en_n_q;
    valid_d  = valid_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    err_d    = err_q;
    y_d      = y_q;
    cnt_lt_d = cnt_lt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_gt_d = cnt_gt_q;

    case (state_q)
      IDLE: begin
        // Ready is implied by IDLE, so valid alone completes the handshake.
        if (bus.req_valid_in) begin
          a_d      = bus.req_a_in;
          b_d      = bus.req_b_in;
          en_n_d   = 1'b0;
          settle_d = SETTLE_LOAD;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      SAMPLE: begin
        y_d   = bus.cmp_y_in;
        lt_d  = bus.cmp_carry_in & ~bus.cmp_zero_in;
        eq_d  = bus.cmp_zero_in  & ~bus.cmp_carry_in;
        gt_d  = ~bus.cmp_carry_in & ~bus.cmp_zero_in;
        err_d = bus.cmp_carry_in & bus.cmp_zero_in;
        if (lt_d) cnt_lt_d = sat_inc(cnt_lt_q);
        if (eq_d) cnt_eq_d = sat_inc(cnt_eq_q);
        if (gt_d) cnt_gt_d = sat_inc(cnt_gt_q);
        valid_d = 1'b1;
        en_n_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any increment taken in the same cycle.
    if (cnt_clr_in) begin
      cnt_lt_d = '0;
      cnt_eq_d = '0;
      cnt_gt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      en_n_q   <= 1'b1;
      valid_q  <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      err_q    <= 1'b0;
      y_q      <= '0;
      cnt_lt_q <= '0;
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      en_n_q   <= en_n_d;
      valid_q  <= valid_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      err_q    <= err_d;
      y_q      <= y_d;
      cnt_lt_q <= cnt_lt_d;
      cnt_eq_q <= cnt_eq_d;
      cnt_gt_q <= cnt_gt_d;
    end
  end

  assign bus.req_ready_out = (state_q == IDLE);
  assign bus.cmp_a_out     = a_q;
  assign bus.cmp_b_out     = b_q;
  assign bus.cmp_en_n_out  = en_n_q;
  assign bus.rsp_valid_out = valid_q;
  assign bus.rsp_lt_out    = lt_q;
  assign bus.rsp_eq_out    = eq_q;
  assign bus.rsp_gt_out    = gt_q;
  assign bus.rsp_err_out   = err_q;
  assign bus.rsp_y_out     = y_q;
  assign cnt_lt_out        = cnt_lt_q;
  assign cnt_eq_out        = cnt_eq_q;
  assign cnt_gt_out        = cnt_gt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cmp_seq_driver
// ----------------------------------------------------------------------------
// Directed bench for cmp_seq_driver. Instance A: SETTLE=1, CNT_W=2 (lets the
// counters saturate quickly). Instance B: SETTLE=4, CNT_W=16 (long DRIVE
// window for the mid-operation reset). Each instance sees a behavioural
// comparator: y=A-B, carry=A<B, zero=A==B, with a force that sets both flags.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cmp_seq_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        clr_a, clr_b;
  logic        force_a;
  logic [1:0]  cnt_lt_a, cnt_eq_a, cnt_gt_a;
  logic [15:0] cnt_lt_b, cnt_eq_b, cnt_gt_b;

  int total = 0;
  int bad   = 0;
  int lat;

  cmp_seq_driver_if #(.WIDTH(8)) ifa ();
  cmp_seq_driver_if #(.WIDTH(8)) ifb ();

  cmp_seq_driver #(.WIDTH(8), .SETTLE(1), .CNT_W(2)) u_dut_a (
    .clk_in     (clk),
    .rst_n_in   (rst_a_n),
    .bus        (ifa),
    .cnt_clr_in (clr_a),
    .cnt_lt_out (cnt_lt_a),
    .cnt_eq_out (cnt_eq_a),
    .cnt_gt_out (cnt_gt_a)
  );

  cmp_seq_driver #(.WIDTH(8), .SETTLE(4), .CNT_W(16)) u_dut_b (
    .clk_in     (clk),
    .rst_n_in   (rst_b_n),
    .bus        (ifb),
    .cnt_clr_in (clr_b),
    .cnt_lt_out (cnt_lt_b),
    .cnt_eq_out (cnt_eq_b),
    .cnt_gt_out (cnt_gt_b)
  );

  // Behavioural comparators
  always_comb begin
    ifa.cmp_y_in     = ifa.cmp_a_out - ifa.cmp_b_out;
    ifa.cmp_carry_in = force_a | (ifa.cmp_a_out < ifa.cmp_b_out);
    ifa.cmp_zero_in  = force_a | (ifa.cmp_a_out == ifa.cmp_b_out);
  end

  always_comb begin
    ifb.cmp_y_in     = ifb.cmp_a_out - ifb.cmp_b_out;
    ifb.cmp_carry_in = (ifb.cmp_a_out < ifb.cmp_b_out);
    ifb.cmp_zero_in  = (ifb.cmp_a_out == ifb.cmp_b_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [7:0] a, input logic [7:0] b);
    ifa.req_valid_in = 1'b1;
    ifa.req_a_in     = a;
    ifa.req_b_in     = b;
    tick();
    ifa.req_valid_in = 1'b0;
  endtask

  task automatic accept_b(input logic [7:0] a, input logic [7:0] b);
    ifb.req_valid_in = 1'b1;
    ifb.req_a_in     = a;
    ifb.req_b_in     = b;
    tick();
    ifb.req_valid_in = 1'b0;
  endtask

  // Edges from the accept edge until rsp_valid is seen (bounded).
  task automatic wait_valid_a(output int n);
    n = 0;
    while (ifa.rsp_valid_out !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid_b(output int n);
    n = 0;
    while (ifb.rsp_valid_out !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [3:0] flags_a();
    return {ifa.rsp_lt_out, ifa.rsp_eq_out, ifa.rsp_gt_out, ifa.rsp_err_out};
  endfunction

  function automatic logic [3:0] flags_b();
    return {ifb.rsp_lt_out, ifb.rsp_eq_out, ifb.rsp_gt_out, ifb.rsp_err_out};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; force_a = 1'b0;
    ifa.req_valid_in = 1'b0; ifa.req_a_in = '0; ifa.req_b_in = '0; ifa.rsp_ready_in = 1'b0;
    ifb.req_valid_in = 1'b0; ifb.req_a_in = '0; ifb.req_b_in = '0; ifb.rsp_ready_in = 1'b0;
    tick();
    tick();

    // ---- reset state (A) ----
    chk("rst_ctl_a", {ifa.req_ready_out, ifa.rsp_valid_out, ifa.cmp_en_n_out}, 3'b101);
    chk("rst_ops_a", {ifa.cmp_a_out, ifa.cmp_b_out, ifa.rsp_y_out}, 24'h0);
    chk("rst_flags_a", flags_a(), 4'b0000);
    chk("rst_cnt_a", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, 6'd0);
    chk("rst_ctl_b", {ifb.req_ready_out, ifb.rsp_valid_out, ifb.cmp_en_n_out}, 3'b101);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick();

    // ---- A=10, B=13 : less via carry ----
    ifa.rsp_ready_in = 1'b1;
    accept_a(8'd10, 8'd13);
    chk("drive_ops", {ifa.cmp_a_out, ifa.cmp_b_out}, {8'd10, 8'd13});
    chk("drive_ctl", {ifa.req_ready_out, ifa.rsp_valid_out, ifa.cmp_en_n_out}, 3'b000);
    wait_valid_a(lat);
    chk("lat_a", lat, 2);
    chk("lt_flags", flags_a(), 4'b1000);
    chk("lt_y", ifa.rsp_y_out, 8'hFD);
    chk("lt_en_n", ifa.cmp_en_n_out, 1'b1);
    chk("lt_cnt", cnt_lt_a, 2'd1);
    tick();
    chk("hs_ctl", {ifa.req_ready_out, ifa.rsp_valid_out}, 2'b10);

    // ---- counter clear in idle ----
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr_idle", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, 6'd0);

    // ---- back-to-back gt, eq, gt ----
    accept_a(8'd13, 8'd10);
    wait_valid_a(lat);
    chk("b2b1_flags", flags_a(), 4'b0010);
    chk("b2b1_y", ifa.rsp_y_out, 8'h03);
    tick();
    accept_a(8'd10, 8'd10);
    wait_valid_a(lat);
    chk("b2b2_flags", flags_a(), 4'b0100);
    chk("b2b2_y", ifa.rsp_y_out, 8'h00);
    tick();
    accept_a(8'd11, 8'd10);
    wait_valid_a(lat);
    chk("b2b3_flags", flags_a(), 4'b0010);
    chk("b2b3_y", ifa.rsp_y_out, 8'h01);
    tick();
    chk("b2b_cnt", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, {2'd0, 2'd1, 2'd2});

    // ---- back-pressure: rsp held, new request refused ----
    ifa.rsp_ready_in = 1'b0;
    accept_a(8'd200, 8'd100);
    wait_valid_a(lat);
    ifa.req_valid_in = 1'b1;
    ifa.req_a_in     = 8'd1;
    ifa.req_b_in     = 8'd2;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ctl", {ifa.rsp_valid_out, ifa.req_ready_out}, 2'b10);
      chk("hold_rsp", {flags_a(), ifa.rsp_y_out}, {4'b0010, 8'h64});
      chk("hold_ops", {ifa.cmp_a_out, ifa.cmp_b_out}, {8'd200, 8'd100});
      tick();
    end
    ifa.req_valid_in = 1'b0;
    ifa.rsp_ready_in = 1'b1;
    tick();
    chk("hold_release", {ifa.rsp_valid_out, ifa.req_ready_out}, 2'b01);
    chk("hold_ops_kept", {ifa.cmp_a_out, ifa.cmp_b_out}, {8'd200, 8'd100});
    chk("hold_cnt", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, {2'd0, 2'd1, 2'd3});

    // ---- inconsistent flags ----
    force_a = 1'b1;
    accept_a(8'd5, 8'd5);
    wait_valid_a(lat);
    chk("err_flags", flags_a(), 4'b0001);
    chk("err_cnt", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, {2'd0, 2'd1, 2'd3});
    tick();
    force_a = 1'b0;

    // ---- saturation (CNT_W=2) ----
    for (int i = 0; i < 4; i++) begin
      accept_a(8'd8, 8'd8);
      wait_valid_a(lat);
      tick();
    end
    chk("sat_eq", cnt_eq_a, 2'd3);
    accept_a(8'd50, 8'd1);
    wait_valid_a(lat);
    chk("sat_gt", cnt_gt_a, 2'd3);
    tick();

    // ---- clear coincident with SAMPLE ----
    accept_a(8'd7, 8'd7);
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr_samp_rsp", {ifa.rsp_valid_out, flags_a()}, 5'b1_0100);
    chk("clr_samp_cnt", {cnt_lt_a, cnt_eq_a, cnt_gt_a}, 6'd0);
    tick();
    chk("clr_samp_idle", ifa.req_ready_out, 1'b1);

    // ---- instance B: SETTLE=4 latency ----
    ifb.rsp_ready_in = 1'b1;
    accept_b(8'd3, 8'd9);
    chk("b_ops", {ifb.cmp_a_out, ifb.cmp_b_out}, {8'd3, 8'd9});
    wait_valid_b(lat);
    chk("lat_b", lat, 5);
    chk("b_flags", flags_b(), 4'b1000);
    chk("b_y", ifb.rsp_y_out, 8'hFA);
    chk("b_cnt", cnt_lt_b, 16'd1);
    tick();

    // ---- instance B: async reset during DRIVE ----
    accept_b(8'd9, 8'd3);
    tick();
    tick();
    chk("b_drive", {ifb.rsp_valid_out, ifb.cmp_en_n_out, ifb.req_ready_out}, 3'b000);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("b_arst_ctl", {ifb.req_ready_out, ifb.rsp_valid_out, ifb.cmp_en_n_out}, 3'b101);
    chk("b_arst_ops", {ifb.cmp_a_out, ifb.cmp_b_out}, 16'h0);
    chk("b_arst_cnt", {cnt_lt_b, cnt_eq_b, cnt_gt_b}, 48'd0);
    tick();
    rst_b_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("b_dropped", {ifb.rsp_valid_out, ifb.cmp_en_n_out, ifb.req_ready_out}, 3'b011);
    chk("b_dropped_cnt", {cnt_lt_b, cnt_eq_b, cnt_gt_b}, 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
